// File: rtl/match_scoreboard.sv
// Cycle-based output comparator: counts samples and mismatches inside a
// start/stop window, latches the first mismatch index and sticky per-bit flags.
module match_scoreboard #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned TIMEOUT_SAMPLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] ref_in,
  input  logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] care_mask,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] bit_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A timeout larger than the counter can hold can never be reached.
  localparam logic [63:0]      CNT_MAX = (CNT_W >= 64) ? '1 : ((64'd1 << CNT_W) - 64'd1);
  localparam bit               TO_EN   = (TIMEOUT_SAMPLES != 0) && (64'(TIMEOUT_SAMPLES) <= CNT_MAX);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_SAMPLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic             fvalid_q, fvalid_d;
  logic [WIDTH-1:0] bit_err_q, bit_err_d;
  logic             timed_out_q, timed_out_d;
  logic [WIDTH-1:0] diff;
  logic             mis;

  assign diff = (ref_in ^ dut_in) & care_mask;
  assign mis  = |diff;

  always_comb begin
    state_d     = state_q;
    samples_d   = samples_q;
    errors_d    = errors_q;
    fidx_d      = fidx_q;
    fvalid_d    = fvalid_q;
    bit_err_d   = bit_err_q;
    timed_out_d = timed_out_q;

    if (start) begin
      state_d     = RUN;
      samples_d   = '0;
      errors_d    = '0;
      fidx_d      = '0;
      fvalid_d    = 1'b0;
      bit_err_d   = '0;
      timed_out_d = 1'b0;
    end else if (state_q == RUN) begin
      if (stop) begin
        state_d = DONE;
      end else begin
        if (samples_q != '1) samples_d = samples_q + ONE;
        if (mis) begin
          if (errors_q != '1) errors_d = errors_q + ONE;
          if (!fvalid_q) begin
            fidx_d   = samples_q;
            fvalid_d = 1'b1;
          end
        end
        bit_err_d = bit_err_q | diff;
        if (TO_EN && (samples_d == TO_CNT)) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      samples_q   <= '0;
      errors_q    <= '0;
      fidx_q      <= '0;
      fvalid_q    <= 1'b0;
      bit_err_q   <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samples_q   <= samples_d;
      errors_q    <= errors_d;
      fidx_q      <= fidx_d;
      fvalid_q    <= fvalid_d;
      bit_err_q   <= bit_err_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign timed_out       = timed_out_q;
  assign samples         = samples_q;
  assign errors          = errors_q;
  assign first_err_idx   = fidx_q;
  assign first_err_valid = fvalid_q;
  assign bit_err         = bit_err_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Bench for match_scoreboard: a behavioural model predicts the main instance
// each cycle; extra instances cover the timeout and counter saturation.
module tb_match_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] ref_in = '0;
  logic [7:0] dut_in = '0;
  logic [7:0] care_mask = '0;

  always #5 clk = ~clk;

  // main instance: WIDTH=8, default CNT_W/TIMEOUT
  logic        o_busy, o_done, o_to, o_fv;
  logic [31:0] o_samples, o_errors, o_fidx;
  logic [7:0]  o_be;

  match_scoreboard #(.WIDTH(8)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .ref_in(ref_in), .dut_in(dut_in), .care_mask(care_mask),
    .busy(o_busy), .done(o_done), .timed_out(o_to),
    .samples(o_samples), .errors(o_errors), .first_err_idx(o_fidx),
    .first_err_valid(o_fv), .bit_err(o_be)
  );

  // timeout instance
  logic        t_busy, t_done, t_to, t_fv;
  logic [31:0] t_samples, t_errors, t_fidx;
  logic [7:0]  t_be;

  match_scoreboard #(.WIDTH(8), .CNT_W(32), .TIMEOUT_SAMPLES(8)) u_to (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .ref_in(ref_in), .dut_in(dut_in), .care_mask(care_mask),
    .busy(t_busy), .done(t_done), .timed_out(t_to),
    .samples(t_samples), .errors(t_errors), .first_err_idx(t_fidx),
    .first_err_valid(t_fv), .bit_err(t_be)
  );

  // saturation instance
  logic       s_busy, s_done, s_to, s_fv;
  logic [2:0] s_samples, s_errors, s_fidx;
  logic [3:0] s_be;

  match_scoreboard #(.WIDTH(4), .CNT_W(3), .TIMEOUT_SAMPLES(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .ref_in(ref_in[3:0]), .dut_in(dut_in[3:0]), .care_mask(care_mask[3:0]),
    .busy(s_busy), .done(s_done), .timed_out(s_to),
    .samples(s_samples), .errors(s_errors), .first_err_idx(s_fidx),
    .first_err_valid(s_fv), .bit_err(s_be)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        to;
    logic [31:0] samples;
    logic [31:0] errors;
    logic [31:0] fidx;
    logic        fv;
    logic [7:0]  be;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_mis = 0;

  // model state: 0 idle, 1 run, 2 done
  int          e_st = 0;
  logic [31:0] e_samples = '0, e_errors = '0, e_fidx = '0;
  logic        e_fv = 1'b0, e_to = 1'b0;
  logic [7:0]  e_be = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    e_st = 0; e_samples = '0; e_errors = '0; e_fidx = '0;
    e_fv = 1'b0; e_to = 1'b0; e_be = '0;
    exp_q.delete();
  endtask

  task automatic model(input logic s, input logic p, input logic [7:0] r, input logic [7:0] d,
                       input logic [7:0] m);
    logic [7:0] df;
    exp_t e;
    if (s) begin
      e_st = 1; e_samples = '0; e_errors = '0; e_fidx = '0;
      e_fv = 1'b0; e_to = 1'b0; e_be = '0;
    end else if (e_st == 1) begin
      if (p) e_st = 2;
      else begin
        df = (r ^ d) & m;
        if (df != 8'h00) begin
          if (!e_fv) begin e_fidx = e_samples; e_fv = 1'b1; end
          if (e_errors != 32'hFFFF_FFFF) e_errors = e_errors + 32'd1;
        end
        if (e_samples != 32'hFFFF_FFFF) e_samples = e_samples + 32'd1;
        e_be = e_be | df;
        if (e_samples == 32'd100000) begin e_st = 2; e_to = 1'b1; end
      end
    end
    e.busy = (e_st == 1); e.done = (e_st == 2); e.to = e_to;
    e.samples = e_samples; e.errors = e_errors; e.fidx = e_fidx;
    e.fv = e_fv; e.be = e_be;
    exp_q.push_back(e);
  endtask

  // Drive one cycle on the falling edge, compare main outputs after the rising edge.
  task automatic step(input logic s, input logic p, input logic [7:0] r, input logic [7:0] d,
                      input logic [7:0] m);
    exp_t e;
    @(negedge clk);
    start = s; stop = p; ref_in = r; dut_in = d; care_mask = m;
    model(s, p, r, d, m);
    @(posedge clk); #1;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_mis++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("busy", 32'(o_busy), 32'(e.busy));
      chk("done", 32'(o_done), 32'(e.done));
      chk("timed_out", 32'(o_to), 32'(e.to));
      chk("samples", o_samples, e.samples);
      chk("errors", o_errors, e.errors);
      chk("first_err_idx", o_fidx, e.fidx);
      chk("first_err_valid", 32'(o_fv), 32'(e.fv));
      chk("bit_err", 32'(o_be), 32'(e.be));
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_samples", o_samples, 32'd0);
    chk("rst_errors", o_errors, 32'd0);
    chk("rst_fv", 32'(o_fv), 32'd0);
    chk("rst_be", 32'(o_be), 32'd0);
    chk("rst_to_busy", 32'(t_busy), 32'd0);
    chk("rst_sat_samples", 32'(s_samples), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // matching stream; the timeout instance closes after its 8th sample
    step(1, 0, 8'h01, 8'h01, 8'h01);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8'h01, 8'h01, 8'h01);
      if (i == 6) begin
        chk("to_busy_at7", 32'(t_busy), 32'd1);
        chk("to_samples_at7", t_samples, 32'd7);
        chk("to_done_at7", 32'(t_done), 32'd0);
      end
      if (i == 7) begin
        chk("to_done_at8", 32'(t_done), 32'd1);
        chk("to_flag_at8", 32'(t_to), 32'd1);
        chk("to_samples_at8", t_samples, 32'd8);
        chk("to_busy_at8", 32'(t_busy), 32'd0);
      end
    end
    step(0, 1, 8'h01, 8'h01, 8'h01);
    chk("match_samples", o_samples, 32'd20);
    chk("match_errors", o_errors, 32'd0);
    chk("match_fv", 32'(o_fv), 32'd0);
    chk("match_done", 32'(o_done), 32'd1);
    chk("match_to", 32'(o_to), 32'd0);
    chk("to_hold_samples", t_samples, 32'd8);
    chk("to_hold_done", 32'(t_done), 32'd1);
    chk("to_hold_flag", 32'(t_to), 32'd1);
    chk("sat_match_samples", 32'(s_samples), 32'd7);
    chk("sat_match_errors", 32'(s_errors), 32'd0);

    // injected mismatches: bit 3 at sample 5, bit 0 at sample 12
    step(1, 0, 8'hA5, 8'hA5, 8'hFF);
    for (int i = 0; i < 16; i++)
      step(0, 0, 8'hA5, 8'hA5 ^ ((i == 5) ? 8'h08 : (i == 12) ? 8'h01 : 8'h00), 8'hFF);
    step(0, 1, 8'hA5, 8'hA5, 8'hFF);
    chk("inj_errors", o_errors, 32'd2);
    chk("inj_fidx", o_fidx, 32'd5);
    chk("inj_be", 32'(o_be), 32'h09);
    chk("inj_samples", o_samples, 32'd16);

    // masking, then restart with full mask
    step(1, 0, 8'h05, 8'h01, 8'h03);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h05, 8'h01, 8'h03);
    chk("mask_errors", o_errors, 32'd0);
    chk("mask_be", 32'(o_be), 32'd0);
    step(1, 0, 8'h05, 8'h01, 8'h0F);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h05, 8'h01, 8'h0F);
    step(0, 1, 8'h05, 8'h05, 8'h0F);
    chk("unmask_errors", o_errors, 32'd3);
    chk("unmask_fidx", o_fidx, 32'd0);
    chk("unmask_be", 32'(o_be), 32'h04);

    // all-zero care mask
    step(1, 0, 8'h00, 8'hFF, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 8'hFF, 8'h00);
    step(0, 1, 8'h00, 8'hFF, 8'h00);
    chk("nocare_samples", o_samples, 32'd5);
    chk("nocare_errors", o_errors, 32'd0);

    // reset mid-window, between clock edges
    step(1, 0, 8'h00, 8'h01, 8'hFF);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h01, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_busy", 32'(o_busy), 32'd0);
    chk("amid_done", 32'(o_done), 32'd0);
    chk("amid_samples", o_samples, 32'd0);
    chk("amid_errors", o_errors, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;

    // stop while idle is ignored
    step(0, 1, 8'h00, 8'h00, 8'hFF);
    chk("idle_stop_done", 32'(o_done), 32'd0);
    chk("idle_stop_busy", 32'(o_busy), 32'd0);

    // start and stop together, then restart after 4 errors
    step(1, 1, 8'h00, 8'h00, 8'hFF);
    chk("ss_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 8'h80, 8'hFF);
    chk("pre_restart_errors", o_errors, 32'd4);
    step(1, 0, 8'h00, 8'h80, 8'hFF);
    chk("restart_errors", o_errors, 32'd0);
    chk("restart_samples", o_samples, 32'd0);
    step(0, 0, 8'h00, 8'h10, 8'hFF);
    chk("restart_fidx", o_fidx, 32'd0);
    chk("restart_fv", 32'(o_fv), 32'd1);
    step(0, 1, 8'h00, 8'h00, 8'hFF);

    // saturation of the 3-bit instance
    step(1, 0, 8'h00, 8'h0F, 8'h0F);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 8'h0F, 8'h0F);
    chk("sat_samples", 32'(s_samples), 32'd7);
    chk("sat_errors", 32'(s_errors), 32'd7);
    chk("sat_fidx", 32'(s_fidx), 32'd0);
    chk("sat_fv", 32'(s_fv), 32'd1);
    chk("sat_busy", 32'(s_busy), 32'd1);
    step(0, 1, 8'h00, 8'h00, 8'h0F);
    chk("sat_done", 32'(s_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
